// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : shared types, control encodings and helpers for load_store_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Same encodings as the control unit drives
  localparam logic [1:0] WSEL_B    = 2'b00;
  localparam logic [1:0] WSEL_H    = 2'b01;
  localparam logic [1:0] WSEL_W    = 2'b10;
  localparam logic [1:0] WSEL_NONE = 2'b11;

  localparam logic [2:0] RSEL_LB   = 3'b000;
  localparam logic [2:0] RSEL_LH   = 3'b010;
  localparam logic [2:0] RSEL_LW   = 3'b011;
  localparam logic [2:0] RSEL_LBU  = 3'b100;
  localparam logic [2:0] RSEL_LHU  = 3'b101;
  localparam logic [2:0] RSEL_NONE = 3'b111;

  // Bits needed to hold values 0..n
  function automatic int lsu_cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i <= 16; i++) begin
      if ((32'd1 << i) <= n) w = i + 1;
    end
    return w;
  endfunction

  function automatic logic lsu_misaligned(input lsu_size_e sz, input logic [1:0] a);
    return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if : EX-side controls and data memory bus of the LSU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;
  logic        start;
  logic        MemRW;
  logic [1:0]  WSel;
  logic [2:0]  RSel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  start, MemRW, WSel, RSel, addr, wdata, mem_rdata, mem_ready,
    output busy, done, rdata, misalign, timeout,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output start, MemRW, WSel, RSel, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, rdata, misalign, timeout,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align : byte enables, store replication and load extraction/extension
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e   i_size,
  input  logic        i_sign,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sign & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_H: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sign & w_shift[15]}}, w_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : multi-cycle load/store engine between EX and data memory
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  localparam int TW = lsu_cnt_width(TIMEOUT_CYCLES);

  lsu_state_e  r_state, w_next;
  logic        r_we, r_sign, r_timeout;
  lsu_size_e   r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [TW-1:0] r_wait;

  logic        w_in_valid, w_in_sign, w_in_mis, w_accept, w_req, w_wait_last;
  lsu_size_e   w_in_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep, w_ld_data;

  // Decode the control-unit selects of the op presented this cycle
  always_comb begin
    w_in_valid = 1'b0;
    w_in_size  = SZ_W;
    w_in_sign  = 1'b0;
    if (bus.MemRW) begin
      case (bus.WSel)
        WSEL_B:  begin w_in_valid = 1'b1; w_in_size = SZ_B; end
        WSEL_H:  begin w_in_valid = 1'b1; w_in_size = SZ_H; end
        WSEL_W:  begin w_in_valid = 1'b1; w_in_size = SZ_W; end
        default: ;
      endcase
    end else begin
      case (bus.RSel)
        RSEL_LB:  begin w_in_valid = 1'b1; w_in_size = SZ_B; w_in_sign = 1'b1; end
        RSEL_LH:  begin w_in_valid = 1'b1; w_in_size = SZ_H; w_in_sign = 1'b1; end
        RSEL_LW:  begin w_in_valid = 1'b1; w_in_size = SZ_W; end
        RSEL_LBU: begin w_in_valid = 1'b1; w_in_size = SZ_B; end
        RSEL_LHU: begin w_in_valid = 1'b1; w_in_size = SZ_H; end
        default:  ;
      endcase
    end
  end

  assign w_accept    = (r_state == S_IDLE) && bus.start && w_in_valid;
  assign w_in_mis    = lsu_misaligned(w_in_size, bus.addr[1:0]);
  assign w_req       = (r_state == S_REQ);
  assign w_wait_last = (r_wait == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_in_mis ? S_ERR : S_REQ;
      S_REQ: begin
        if (bus.mem_ready)    w_next = S_DONE;
        else if (w_wait_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_sign    <= 1'b0;
      r_size    <= SZ_B;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_req && !bus.mem_ready && w_wait_last;
      if (w_accept) begin
        r_we    <= bus.MemRW;
        r_sign  <= w_in_sign;
        r_size  <= w_in_size;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_wait  <= '0;
      end else if (w_req && !bus.mem_ready) begin
        r_wait  <= r_wait + 1'b1;
      end
      if (w_req && bus.mem_ready && !r_we) r_rdata <= w_ld_data;
    end
  end

  lsu_lane_align u_align (
    .i_size    (r_size),
    .i_sign    (r_sign),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (bus.mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_ld_data)
  );

  // Bus outputs decode straight from state so reset drops them asynchronously
  assign bus.busy      = w_accept || w_req || (r_state == S_ERR);
  assign bus.done      = (r_state == S_DONE);
  assign bus.misalign  = (r_state == S_ERR);
  assign bus.timeout   = r_timeout;
  assign bus.rdata     = r_rdata;
  assign bus.mem_req   = w_req;
  assign bus.mem_we    = w_req && r_we;
  assign bus.mem_be    = w_req ? w_be : 4'b0000;
  assign bus.mem_wdata = w_req ? w_wdata_rep : 32'h0;
  assign bus.mem_addr  = r_addr[31:2];

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.MemRW = 1'b0; bus.WSel = WSEL_NONE; bus.RSel = RSEL_NONE;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_tests++;
    if ({bus.busy, bus.done, bus.misalign, bus.timeout, bus.mem_req, bus.mem_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.busy, bus.done, bus.misalign, bus.timeout, bus.mem_req, bus.mem_we});
    end
    n_tests++;
    if ({bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.rdata} !== 98'b0) begin
      n_fail++; $display("FAIL reset_data: be=%b addr=%h wdata=%h rdata=%h want all 0",
        bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sb();
    bus.start = 1'b1; bus.MemRW = 1'b1; bus.WSel = WSEL_B;
    bus.addr = 32'h0000_1003; bus.wdata = 32'h0000_00A5; bus.mem_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy0: got %b want 1", bus.busy); end
    step();
    bus.start = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b11_1000) begin
      n_fail++; $display("FAIL sb_req_be: got %b want 111000", {bus.mem_req, bus.mem_we, bus.mem_be});
    end
    n_tests++;
    if (bus.mem_wdata !== 32'hA5A5_A5A5 || bus.mem_addr !== 30'h400) begin
      n_fail++; $display("FAIL sb_bus: wdata=%h addr=%h want a5a5a5a5 400", bus.mem_wdata, bus.mem_addr);
    end
    step();
    n_tests++;
    if ({bus.done, bus.busy, bus.mem_req} !== 3'b100) begin
      n_fail++; $display("FAIL sb_done: done/busy/req=%b want 100", {bus.done, bus.busy, bus.mem_req});
    end
    step();
  endtask

  task automatic do_load(input string nm, input logic [2:0] rs, input logic [31:0] a,
                         input logic [31:0] md, input logic [3:0] exp_be, input logic [31:0] exp_rd);
    bus.start = 1'b1; bus.MemRW = 1'b0; bus.RSel = rs; bus.WSel = WSEL_NONE;
    bus.addr = a; bus.mem_rdata = md; bus.mem_ready = 1'b1;
    step();
    bus.start = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== {2'b10, exp_be} || bus.mem_addr !== a[31:2]) begin
      n_fail++; $display("FAIL %s_bus: req/we/be=%b addr=%h want %b %h", nm,
        {bus.mem_req, bus.mem_we, bus.mem_be}, bus.mem_addr, {2'b10, exp_be}, a[31:2]);
    end
    step();
    n_tests++;
    if (bus.done !== 1'b1 || bus.rdata !== exp_rd) begin
      n_fail++; $display("FAIL %s_rdata: done=%b rdata=%h want 1 %h", nm, bus.done, bus.rdata, exp_rd);
    end
    bus.mem_rdata = 32'h0;
    step();
  endtask

  task automatic test_loads();
    do_load("lb",  RSEL_LB,  32'h0000_2001, 32'h1234_80FF, 4'b0010, 32'hFFFF_FF80);
    do_load("lbu", RSEL_LBU, 32'h0000_2001, 32'h1234_80FF, 4'b0010, 32'h0000_0080);
    do_load("lh",  RSEL_LH,  32'h0000_2002, 32'h9ABC_0000, 4'b1100, 32'hFFFF_9ABC);
    do_load("lhu", RSEL_LHU, 32'h0000_2002, 32'h9ABC_0000, 4'b1100, 32'h0000_9ABC);
    do_load("lw",  RSEL_LW,  32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
  endtask

  task automatic test_misalign();
    bit seen_req;
    seen_req = 1'b0;
    bus.start = 1'b1; bus.MemRW = 1'b0; bus.RSel = RSEL_LW; bus.addr = 32'h0000_2002;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111;
    #1;
    seen_req |= bus.mem_req;
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mis_busy0: got %b want 1", bus.busy); end
    step();
    bus.start = 1'b0;
    #1;
    seen_req |= bus.mem_req;
    n_tests++;
    if ({bus.misalign, bus.busy, bus.done} !== 3'b110) begin
      n_fail++; $display("FAIL mis_pulse: misalign/busy/done=%b want 110", {bus.misalign, bus.busy, bus.done});
    end
    step();
    seen_req |= bus.mem_req;
    n_tests++;
    if ({bus.misalign, bus.busy, seen_req} !== 3'b000 || bus.rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mis_after: misalign/busy/req_seen=%b rdata=%h want 000 deadbeef",
        {bus.misalign, bus.busy, seen_req}, bus.rdata);
    end
  endtask

  task automatic test_wait_states();
    int stable_bad;
    stable_bad = 0;
    bus.start = 1'b1; bus.MemRW = 1'b1; bus.WSel = WSEL_W;
    bus.addr = 32'h0000_3000; bus.wdata = 32'h1122_3344; bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h5555_5555;
    #1;
    if (bus.busy !== 1'b1) stable_bad++;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.start = 1'b0;
      bus.mem_ready = (k == 4);
      #1;
      if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.busy, bus.done} !== 8'b11_1111_10 ||
          bus.mem_wdata !== 32'h1122_3344 || bus.mem_addr !== 30'hC00) stable_bad++;
    end
    n_tests++;
    if (stable_bad != 0) begin
      n_fail++; $display("FAIL ws_stable: %0d bad cycles want 0", stable_bad);
    end
    step();
    bus.mem_ready = 1'b0;
    n_tests++;
    if ({bus.done, bus.busy, bus.mem_req, bus.timeout} !== 4'b1000) begin
      n_fail++; $display("FAIL ws_done: done/busy/req/timeout=%b want 1000",
        {bus.done, bus.busy, bus.mem_req, bus.timeout});
    end
    n_tests++;
    if (bus.rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ws_rdata_kept: got %h want deadbeef", bus.rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    int req_cnt;
    req_cnt = 0;
    bus.start = 1'b1; bus.MemRW = 1'b0; bus.RSel = RSEL_LW;
    bus.addr = 32'h0000_4000; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h7777_7777;
    for (int k = 1; k <= 4; k++) begin
      step();
      // late starts while busy must not disturb the access
      bus.start = (k <= 3); bus.MemRW = 1'b1; bus.WSel = WSEL_W; bus.addr = 32'h0000_5000;
      #1;
      if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === 30'h1000 &&
          bus.timeout === 1'b0) req_cnt++;
    end
    n_tests++;
    if (req_cnt != 4) begin n_fail++; $display("FAIL to_req: got %0d good req cycles want 4", req_cnt); end
    step();
    n_tests++;
    if ({bus.timeout, bus.mem_req, bus.done, bus.busy} !== 4'b1000) begin
      n_fail++; $display("FAIL to_pulse: timeout/req/done/busy=%b want 1000",
        {bus.timeout, bus.mem_req, bus.done, bus.busy});
    end
    n_tests++;
    if (bus.rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL to_rdata_kept: got %h want deadbeef", bus.rdata);
    end
    step();
    n_tests++;
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle: got %b want 0", bus.timeout); end
    idle_inputs();
    step();
  endtask

  task automatic test_ignored();
    logic [2:0] codes [3];
    codes[0] = 3'b111; codes[1] = 3'b001; codes[2] = 3'b110;
    bus.start = 1'b1; bus.MemRW = 1'b1; bus.WSel = WSEL_NONE; bus.addr = 32'h0000_6000;
    bus.mem_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_st_busy: got %b want 0", bus.busy); end
    step();
    n_tests++;
    if ({bus.mem_req, bus.done, bus.misalign, bus.busy} !== 4'b0000) begin
      n_fail++; $display("FAIL ign_st_state: req/done/mis/busy=%b want 0000",
        {bus.mem_req, bus.done, bus.misalign, bus.busy});
    end
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1; bus.MemRW = 1'b0; bus.RSel = codes[i]; bus.addr = 32'h0000_6001;
      #1;
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_ld_busy: rsel=%b got %b want 0", codes[i], bus.busy); end
      step();
      n_tests++;
      if ({bus.mem_req, bus.misalign} !== 2'b00) begin
        n_fail++; $display("FAIL ign_ld_state: rsel=%b req/mis=%b want 00", codes[i], {bus.mem_req, bus.misalign});
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.MemRW = 1'b0; bus.RSel = RSEL_LW; bus.addr = 32'h0000_7000;
    bus.mem_ready = 1'b0;
    step();
    bus.start = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rm_pre_req: got %b want 1", bus.mem_req); end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_req, bus.busy, bus.mem_we, bus.mem_be} !== 7'b0 || bus.mem_addr !== 30'h0 ||
        bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL rm_async: req/busy/we/be=%b addr=%h rdata=%h want 0",
        {bus.mem_req, bus.busy, bus.mem_we, bus.mem_be}, bus.mem_addr, bus.rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    step();
    n_tests++;
    if ({bus.mem_req, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL rm_abandoned: req/done=%b want 00", {bus.mem_req, bus.done});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sb();
    test_loads();
    test_misalign();
    test_wait_states();
    test_timeout();
    test_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
